// File: rtl/can_bus_arbiter_if.sv
// ============================================================================
// Module      : can_bus_arbiter_if
// Description : Host, agent and CAN-controller bus bundle for the arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface can_bus_arbiter_if #(
    parameter int CAN_NUMS = 4,
    parameter int AW       = 8,
    parameter int DW       = 8
);
    logic [CAN_NUMS-1:0]    host_cs_n;
    logic                   host_we;
    logic                   host_re;
    logic [AW-1:0]          host_addr;
    logic [DW-1:0]          host_din;
    logic [DW*CAN_NUMS-1:0] host_dout;

    logic [CAN_NUMS-1:0]    agt_req;
    logic [CAN_NUMS-1:0]    agt_we;
    logic [AW*CAN_NUMS-1:0] agt_addr;
    logic [DW*CAN_NUMS-1:0] agt_din;
    logic [CAN_NUMS-1:0]    agt_ack;
    logic [DW*CAN_NUMS-1:0] agt_dout;
    logic [CAN_NUMS-1:0]    agt_on;

    logic [CAN_NUMS-1:0]    can_cs_n;
    logic [CAN_NUMS-1:0]    can_we;
    logic [CAN_NUMS-1:0]    can_re;
    logic [AW*CAN_NUMS-1:0] can_addr;
    logic [DW*CAN_NUMS-1:0] can_din;
    logic [DW*CAN_NUMS-1:0] can_dout;

    logic [CAN_NUMS-1:0]    col_flag;
    logic [CAN_NUMS-1:0]    col_clr;

    modport slave (
        input  host_cs_n, host_we, host_re, host_addr, host_din,
        input  agt_req, agt_we, agt_addr, agt_din,
        input  can_dout, col_clr,
        output host_dout, agt_ack, agt_dout, agt_on,
        output can_cs_n, can_we, can_re, can_addr, can_din, col_flag
    );

    modport master (
        output host_cs_n, host_we, host_re, host_addr, host_din,
        output agt_req, agt_we, agt_addr, agt_din,
        output can_dout, col_clr,
        input  host_dout, agt_ack, agt_dout, agt_on,
        input  can_cs_n, can_we, can_re, can_addr, can_din, col_flag
    );
endinterface

`default_nettype wire

// File: rtl/can_bus_arbiter.sv
// ============================================================================
// Module      : can_bus_arbiter
// Description : Per-channel arbitration of CAN controller access between a
//               local-bus host (pass-through) and an autonomous agent.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module can_bus_arbiter #(
    parameter int CAN_NUMS = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RD_LAT   = 2,
    parameter int U_DLY    = 1
) (
    input  logic             clk,
    input  logic             rst,
    can_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ACC   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    wire [CAN_NUMS-1:0]    w_can_cs_n;
    wire [CAN_NUMS-1:0]    w_can_we;
    wire [CAN_NUMS-1:0]    w_can_re;
    wire [AW*CAN_NUMS-1:0] w_can_addr;
    wire [DW*CAN_NUMS-1:0] w_can_din;
    wire [DW*CAN_NUMS-1:0] w_host_dout;
    wire [DW*CAN_NUMS-1:0] w_agt_dout;
    wire [CAN_NUMS-1:0]    w_agt_ack;
    wire [CAN_NUMS-1:0]    w_agt_on;
    wire [CAN_NUMS-1:0]    w_col_flag;

    // U_DLY exists only for delay-annotated simulation flows; no delay is applied here.
    if (CAN_NUMS < 1 || CAN_NUMS > 8 || RD_LAT < 1 || RD_LAT > 7 || U_DLY < 0) begin : g_bad_params
    end

    for (genvar i = 0; i < CAN_NUMS; i++) begin : g_ch
        state_t        r_state;
        logic [1:0]    r_guard;
        logic [2:0]    r_wait;
        logic          r_ack;
        logic          r_col;
        logic          r_cs_n;
        logic          r_we;
        logic          r_re;
        logic          r_lat_we;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_din;
        logic [DW-1:0] r_dout;
        logic          w_pass;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= IDLE;
                r_guard  <= 2'd0;
                r_wait   <= 3'd0;
                r_ack    <= 1'b0;
                r_col    <= 1'b0;
                r_cs_n   <= 1'b1;
                r_we     <= 1'b0;
                r_re     <= 1'b0;
                r_lat_we <= 1'b0;
                r_addr   <= '0;
                r_din    <= '0;
                r_dout   <= '0;
            end else begin
                r_ack <= 1'b0;

                // Guard only accumulates in IDLE so a request held through DONE must re-qualify.
                if (!bus.host_cs_n[i] || r_state != IDLE)
                    r_guard <= 2'd0;
                else if (r_guard != 2'd2)
                    r_guard <= r_guard + 2'd1;

                if (r_state != IDLE && !bus.host_cs_n[i])
                    r_col <= 1'b1;
                else if (bus.col_clr[i])
                    r_col <= 1'b0;

                case (r_state)
                    IDLE: begin
                        if (bus.agt_req[i] && r_guard == 2'd2) begin
                            r_state  <= SETUP;
                            r_lat_we <= bus.agt_we[i];
                            r_addr   <= bus.agt_addr[i*AW +: AW];
                            r_din    <= bus.agt_din[i*DW +: DW];
                            r_cs_n   <= 1'b0;
                            r_we     <= 1'b0;
                            r_re     <= 1'b0;
                        end
                    end
                    SETUP: begin
                        r_state <= ACC;
                        r_we    <= r_lat_we;
                        r_re    <= ~r_lat_we;
                    end
                    ACC: begin
                        r_we <= 1'b0;
                        r_re <= 1'b0;
                        if (r_lat_we) begin
                            r_state <= DONE;
                            r_cs_n  <= 1'b1;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_wait  <= 3'(RD_LAT - 1);
                        end
                    end
                    WAIT: begin
                        if (r_wait == 3'd0) begin
                            r_state <= DONE;
                            r_cs_n  <= 1'b1;
                            r_ack   <= 1'b1;
                            r_dout  <= bus.can_dout[i*DW +: DW];
                        end else begin
                            r_wait <= r_wait - 3'd1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end

        // Reset forces the host path immediately, even before the state register clears.
        assign w_pass = (r_state == IDLE) || rst;

        assign w_can_cs_n[i]             = w_pass ? bus.host_cs_n[i] : r_cs_n;
        assign w_can_we[i]               = w_pass ? bus.host_we      : r_we;
        assign w_can_re[i]               = w_pass ? bus.host_re      : r_re;
        assign w_can_addr[i*AW +: AW]    = w_pass ? bus.host_addr    : r_addr;
        assign w_can_din[i*DW +: DW]     = w_pass ? bus.host_din     : r_din;
        assign w_host_dout[i*DW +: DW]   = w_pass ? bus.can_dout[i*DW +: DW] : '0;
        assign w_agt_dout[i*DW +: DW]    = rst ? '0 : r_dout;
        assign w_agt_ack[i]              = r_ack & ~rst;
        assign w_agt_on[i]               = (r_state != IDLE) & ~rst;
        assign w_col_flag[i]             = r_col & ~rst;
    end

    assign bus.can_cs_n  = w_can_cs_n;
    assign bus.can_we    = w_can_we;
    assign bus.can_re    = w_can_re;
    assign bus.can_addr  = w_can_addr;
    assign bus.can_din   = w_can_din;
    assign bus.host_dout = w_host_dout;
    assign bus.agt_dout  = w_agt_dout;
    assign bus.agt_ack   = w_agt_ack;
    assign bus.agt_on    = w_agt_on;
    assign bus.col_flag  = w_col_flag;

endmodule

`default_nettype wire
